// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter slice.
// Owner tags and default bus widths.
package dmem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    DMA  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, DMA and memory bus bundle around the data-memory arbiter.
// slave = arbiter view, master = requester/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_pkg::ADDR_W,
  parameter int DATA_W = dmem_pkg::DATA_W
);

  logic              cpu_mem_read;
  logic              cpu_mem_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wd;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wd;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

  modport slave (
    input  cpu_mem_read, cpu_mem_write,
    input  cpu_addr, cpu_wd,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wd,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_read, mem_write,
    output mem_addr, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_mem_read, cpu_mem_write,
    output cpu_addr, cpu_wd,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wd,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_read, mem_write,
    input  mem_addr, mem_wd,
    output mem_rd
  );

endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating denial counter; at_max flags that
// the waiting requester must be forced through.
module starve_counter #(
  parameter  int MAX = 4,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [W-1:0] cnt;

  assign at_max = (cnt == W'(MAX));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory:
// CPU first, DMA forced through after STARVE_MAX denials.
module dmem_arbiter #(
  parameter int ADDR_W     = dmem_pkg::ADDR_W,
  parameter int DATA_W     = dmem_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input logic           CLK,
  input logic           RST,
  dmem_arbiter_if.slave bus
);

  import dmem_pkg::*;

  owner_t rsp_owner;

  logic              cpu_act;
  logic              cpu_iss;
  logic              cpu_rd;
  logic              gnt;
  logic              force_gnt;
  logic              at_max;
  logic              denied;
  logic              rd_n;
  logic              wr_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wd_n;
  logic              cpu_rv;
  logic              dma_rv;

  assign cpu_act   = bus.cpu_mem_read | bus.cpu_mem_write;
  assign cpu_rd    = bus.cpu_mem_read & ~bus.cpu_mem_write;
  assign force_gnt = bus.dma_req & at_max;
  assign gnt       = ~RST & bus.dma_req
                   & (~cpu_act | force_gnt);
  assign cpu_iss   = ~RST & cpu_act & ~gnt;
  assign denied    = bus.dma_req & ~gnt;

  assign bus.dma_gnt   = gnt;
  assign bus.cpu_stall = cpu_act & gnt;

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (CLK),
    .rst    (RST),
    .inc    (denied),
    .clr    (~denied),
    .at_max (at_max)
  );

  always_comb begin
    rd_n   = 1'b0;
    wr_n   = 1'b0;
    addr_n = '0;
    wd_n   = '0;
    unique case (1'b1)
      gnt: begin
        rd_n   = ~bus.dma_we;
        wr_n   = bus.dma_we;
        addr_n = bus.dma_addr;
        wd_n   = bus.dma_wd;
      end
      cpu_iss: begin
        rd_n   = cpu_rd;
        wr_n   = bus.cpu_mem_write;
        addr_n = bus.cpu_addr;
        wd_n   = bus.cpu_wd;
      end
      default: ;
    endcase
  end

  assign bus.mem_read  = rd_n;
  assign bus.mem_write = wr_n;
  assign bus.mem_addr  = addr_n;
  assign bus.mem_wd    = wd_n;

  // Tag who owns next cycle's mem_rd.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp_owner <= NONE;
    end else if (cpu_iss && cpu_rd) begin
      rsp_owner <= CPU;
    end else if (gnt && !bus.dma_we) begin
      rsp_owner <= DMA;
    end else begin
      rsp_owner <= NONE;
    end
  end

  assign cpu_rv = ~RST & (rsp_owner == CPU);
  assign dma_rv = ~RST & (rsp_owner == DMA);

  assign bus.cpu_rvalid = cpu_rv;
  assign bus.cpu_rdata  = cpu_rv ? bus.mem_rd : '0;
  assign bus.dma_rvalid = dma_rv;
  assign bus.dma_rdata  = dma_rv ? bus.mem_rd : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plan cases plus random traffic against a
// transaction-level model of the data-memory arbiter.
module tb_dmem_arbiter;

  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .STARVE_MAX (SMAX)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  logic [31:0] dev [16];
  logic [31:0] dev_rd;

  assign bus.mem_rd = dev_rd;

  always @(posedge clk) begin
    if (bus.mem_write) dev[bus.mem_addr[5:2]] <= bus.mem_wd;
    if (bus.mem_read) dev_rd <= dev[bus.mem_addr[5:2]];
  end

  logic [31:0] ref_mem [int];
  int          denied;
  bit          exp_crv;
  bit          exp_drv;
  logic [31:0] exp_crd;
  logic [31:0] exp_drd;
  int          n_chk;
  int          n_fail;
  bit          last_gnt;
  bit          last_stall;
  logic        obs_gnt;
  logic        obs_stall;
  logic        obs_rd;
  logic        obs_wr;
  logic [31:0] obs_addr;

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.cpu_mem_read  = 1'b0;
    bus.cpu_mem_write = 1'b0;
    bus.cpu_addr      = '0;
    bus.cpu_wd        = '0;
    bus.dma_req       = 1'b0;
    bus.dma_we        = 1'b0;
    bus.dma_addr      = '0;
    bus.dma_wd        = '0;
  endtask

  // One cycle: check outputs vs. model, then advance the model.
  task automatic cyc();
    bit          act;
    bit          gnt;
    bit          stall;
    bit          ciss;
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    #1;
    act   = bus.cpu_mem_read || bus.cpu_mem_write;
    gnt   = !rst && bus.dma_req
          && (!act || denied >= SMAX);
    stall = act && gnt;
    ciss  = !rst && act && !gnt;
    rd = 0; wr = 0; a = '0; d = '0;
    if (gnt) begin
      rd = !bus.dma_we; wr = bus.dma_we;
      a = bus.dma_addr; d = bus.dma_wd;
    end else if (ciss) begin
      wr = bus.cpu_mem_write; rd = !wr;
      a = bus.cpu_addr; d = bus.cpu_wd;
    end
    chk("dma_gnt", bus.dma_gnt, gnt);
    chk("cpu_stall", bus.cpu_stall, stall);
    chk("mem_read", bus.mem_read, rd);
    chk("mem_write", bus.mem_write, wr);
    chk("mem_addr", bus.mem_addr, a);
    chk("mem_wd", bus.mem_wd, d);
    chk("cpu_rvalid", bus.cpu_rvalid, exp_crv && !rst);
    chk("cpu_rdata", bus.cpu_rdata,
        (exp_crv && !rst) ? exp_crd : 32'h0);
    chk("dma_rvalid", bus.dma_rvalid, exp_drv && !rst);
    chk("dma_rdata", bus.dma_rdata,
        (exp_drv && !rst) ? exp_drd : 32'h0);
    obs_gnt = bus.dma_gnt; obs_stall = bus.cpu_stall;
    obs_rd = bus.mem_read; obs_wr = bus.mem_write;
    obs_addr = bus.mem_addr;
    last_gnt = gnt; last_stall = stall;
    exp_crv = ciss && rd;
    exp_drv = gnt && rd;
    if (rd) begin
      exp_crd = ref_mem[int'(a)];
      exp_drd = ref_mem[int'(a)];
    end
    if (wr) ref_mem[int'(a)] = d;
    denied = (!rst && bus.dma_req && !gnt) ? denied + 1 : 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; denied = 0;
    exp_crv = 0; exp_drv = 0;
    exp_crd = '0; exp_drd = '0;
    for (int i = 0; i < 16; i++) begin
      dev[i] <= (i == 4) ? 32'hDEADBEEF : 32'hC0DE0000 + i;
      ref_mem[i * 4] = (i == 4) ? 32'hDEADBEEF
                                : 32'hC0DE0000 + i;
    end
    dev_rd <= '0;
    idle();
    rst = 1'b1;
    @(negedge clk);
    // Reset with live requests: everything must stay quiet.
    bus.cpu_mem_read = 1'b1;
    bus.dma_req = 1'b1;
    cyc();
    chk("rst_cnt", dut.u_starve.cnt, 0);
    idle();
    rst = 1'b0;
    cyc();
    // CPU-only read of 0x10.
    bus.cpu_mem_read = 1'b1;
    bus.cpu_addr = 32'h10;
    cyc();
    chk("t1_rd", obs_rd, 1);
    chk("t1_stall", obs_stall, 0);
    chk("t1_rvalid", bus.cpu_rvalid, 1);
    chk("t1_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    idle();
    cyc();
    // DMA write then read with idle CPU.
    bus.dma_req = 1'b1; bus.dma_we = 1'b1;
    bus.dma_addr = 32'h20; bus.dma_wd = 32'h12345678;
    cyc();
    chk("t2_wgnt", obs_gnt, 1);
    bus.dma_we = 1'b0; bus.dma_wd = '0;
    cyc();
    chk("t2_rgnt", obs_gnt, 1);
    chk("t2_rvalid", bus.dma_rvalid, 1);
    chk("t2_rdata", bus.dma_rdata, 32'h12345678);
    idle();
    cyc();
    // Starvation: CPU busy every cycle, DMA held.
    bus.cpu_mem_read = 1'b1; bus.cpu_addr = 32'h4;
    bus.dma_req = 1'b1; bus.dma_addr = 32'h8;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("starve_gnt", obs_gnt, (i == 4));
      chk("starve_stall", obs_stall, (i == 4));
      if (i == 4) begin
        bus.dma_req = 1'b0;
        chk("starve_cnt_clr", dut.u_starve.cnt, 0);
      end
    end
    chk("starve_cpu_addr", obs_addr, 32'h4);
    chk("starve_cpu_rd", obs_rd, 1);
    idle();
    cyc();
    // Interleaved CPU then DMA reads.
    bus.cpu_mem_read = 1'b1; bus.cpu_addr = 32'h4;
    cyc();
    chk("il_crv", bus.cpu_rvalid, 1);
    chk("il_crd", bus.cpu_rdata, 32'hC0DE0001);
    chk("il_drv0", bus.dma_rvalid, 0);
    idle();
    bus.dma_req = 1'b1; bus.dma_addr = 32'h8;
    cyc();
    chk("il_drv", bus.dma_rvalid, 1);
    chk("il_drd", bus.dma_rdata, 32'hC0DE0002);
    chk("il_crv0", bus.cpu_rvalid, 0);
    idle();
    cyc();
    // Read and write together: write wins.
    bus.cpu_mem_read = 1'b1; bus.cpu_mem_write = 1'b1;
    bus.cpu_addr = 32'h30; bus.cpu_wd = 32'hA5A5A5A5;
    cyc();
    chk("rw_wr", obs_wr, 1);
    chk("rw_rd", obs_rd, 0);
    chk("rw_norv", bus.cpu_rvalid, 0);
    chk("rw_mem", dev[12], 32'hA5A5A5A5);
    idle();
    cyc();
    // Reset right after a CPU read issue.
    bus.cpu_mem_read = 1'b1; bus.cpu_addr = 32'h10;
    bus.dma_req = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst2_cnt", dut.u_starve.cnt, 0);
    chk("rst2_rv", bus.cpu_rvalid, 0);
    rst = 1'b0;
    bus.dma_req = 1'b0;
    cyc();
    chk("rst2_resume", obs_rd, 1);
    idle();
    cyc();
    // Random traffic obeying the requester hold rules.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!last_stall) begin
        int op;
        op = $urandom_range(0, 7);
        bus.cpu_mem_read  = (op inside {[1:3], 6});
        bus.cpu_mem_write = (op inside {[4:6]});
        bus.cpu_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus.cpu_wd = $urandom;
      end
      if (bus.dma_req && !last_gnt) begin
        if ($urandom_range(0, 15) == 0) bus.dma_req = 1'b0;
      end else begin
        bus.dma_req = ($urandom_range(0, 2) != 0);
        bus.dma_we = $urandom_range(0, 1);
        bus.dma_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus.dma_wd = $urandom;
      end
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk("final_mem", dev[i], ref_mem[i * 4]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - the pipeline MEM stage (CPU port, normally highest priority);
  - a loader/DMA port used for program/data preload and test readback.
- Issues at most one memory access per cycle and routes each 1-cycle-latency read response back to its owner.
- Stalls the CPU when the DMA port must be served, so the DMA port can never be starved.
- Sits between MEM_STAGE and DATA_MEM.

Parameters:
- ADDR_W, 32, address width of both ports and memory.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive cycles a pending DMA request may be denied before it is forced through (must be >= 1).

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- cpu_mem_read  in  1  CPU load request (M[2]).
- cpu_mem_write  in  1  CPU store request (M[1]).
- cpu_addr  in  ADDR_W  CPU address (ALU result).
- cpu_wd  in  DATA_W  CPU store data.
- cpu_stall  out  1  CPU access not issued this cycle; CPU must hold its request.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dma_req  in  1  DMA access request, held until granted.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  ADDR_W  DMA address.
- dma_wd  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA access issued this cycle.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  DATA_W  DMA read data.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data, valid 1 cycle after mem_read.

Behaviour:
- Reset: RST is synchronous and active-high, sampled on the rising edge of CLK.
  - While RST is high: starve_cnt = 0, rsp_owner = NONE.
  - While RST is high, these outputs are forced to 0: cpu_stall, dma_gnt, mem_read, mem_write, cpu_rvalid, dma_rvalid.
  - Reset mid-access discards any in-flight read response.
- Request definitions:
  - cpu_act = cpu_mem_read | cpu_mem_write.
  - If both cpu_mem_read and cpu_mem_write are high, the access is a write; no read response is produced.
- Grant logic (combinational from inputs and state):
  - force = dma_req & (starve_cnt == STARVE_MAX).
  - dma_gnt = dma_req & (~cpu_act | force).
  - cpu_stall = cpu_act & dma_gnt.
  - CPU is issued when cpu_act & ~cpu_stall.
- Memory mux:
  - DMA issued: mem_read = ~dma_we, mem_write = dma_we, mem_addr/mem_wd come from the dma_* inputs.
  - CPU issued: mem_read/mem_write/mem_addr/mem_wd come from the cpu_* inputs (write wins if both are high).
  - Otherwise: mem_read = mem_write = 0, and mem_addr/mem_wd = 0.
- Starvation counter (starve_cnt), width $clog2(STARVE_MAX+1):
  - If dma_req & ~dma_gnt: increment, saturating at STARVE_MAX.
  - Else: clear to 0.
  - Forced grant therefore occurs exactly on the (STARVE_MAX+1)th cycle of continuous denial.
- Response routing (rsp_owner register: NONE / CPU / DMA):
  - Next value = CPU if a CPU read was issued, DMA if a DMA read was issued, otherwise NONE.
  - cpu_rvalid = (rsp_owner == CPU); cpu_rdata = mem_rd when cpu_rvalid, else 0.
  - dma_rvalid and dma_rdata behave the same way for rsp_owner == DMA.
- Latency and throughput:
  - Writes complete in the issue cycle.
  - Read data is returned exactly 1 cycle after issue.
  - Back-to-back reads by either port are supported, one per cycle.
- Requester rules:
  - The CPU must keep its request and operands stable while cpu_stall = 1.
  - The DMA must hold dma_req and its operands until dma_gnt is sampled high.
  - Dropping dma_req before it is granted is allowed and clears starve_cnt.

Decomposition:
- Shared package dmem_pkg holds:
  - owner_t enum: NONE = 2'd0, CPU = 2'd1, DMA = 2'd2.
  - default width constants ADDR_W and DATA_W.
- Sub-module: starve_counter, a saturating counter with inc/clr inputs and an at_max output, reusable by later arbiters.
- Grant, mux and rsp_owner logic stay in the top module.

Test Plan:
- CPU only: read addr 0x10 (mem holds 0xDEADBEEF) -> mem_read = 1 in cycle 0; cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF in cycle 1; cpu_stall never high.
- DMA only, idle CPU: write 0x20 <- 0x12345678, then read 0x20 -> dma_gnt = 1 immediately on each request; dma_rdata = 0x12345678 one cycle after the read grant.
- Starvation (STARVE_MAX = 4): CPU requests every cycle and dma_req is held:
  - dma_gnt = 0 for cycles 0-3, dma_gnt = 1 with cpu_stall = 1 in cycle 4;
  - starve_cnt returns to 0 in cycle 5;
  - the CPU access is issued in cycle 5 with unchanged address.
- Interleaved reads: CPU read 0x4 in cycle n, DMA read 0x8 in cycle n+1 -> cpu_rvalid only in n+1, dma_rvalid only in n+2, each with the correct data and no cross-routing.
- Both cpu_mem_read and cpu_mem_write high, addr 0x30, wd 0xA5A5A5A5 -> mem_write = 1, mem_read = 0, no cpu_rvalid next cycle, memory updated.
- RST asserted in the cycle after a CPU read issue -> cpu_rvalid = 0, starve_cnt = 0, all enables 0; normal arbitration resumes in the first cycle after RST falls.
